// File: rtl/ticket_vending_pkg.sv
`default_nettype none
// ticket_vending_pkg: shared state encoding, default fare constants and distance helper
// for the ticket vending controller.
package ticket_vending_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CALC   = 3'd1,
      ST_PAY    = 3'd2,
      ST_ISSUE  = 3'd3,
      ST_REFUND = 3'd4
   } state_e;

   localparam int unsigned DEF_NUM_STATIONS = 8;
   localparam int unsigned DEF_MAX_TICKETS  = 7;
   localparam int unsigned DEF_FARE_BASE    = 5;
   localparam int unsigned DEF_FARE_STEP    = 5;

   function automatic int unsigned station_dist(input int unsigned a, input int unsigned b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ticket_vending_fsm_fare_calc.sv
`default_nettype none
// fare_calc: distance-based fare for a latched request; cost_o is captured on load_i
// and cleared on clear_i, cost_next_o is the combinational price.
module fare_calc
   import ticket_vending_pkg::*;
#(
   parameter int unsigned STN_W     = 4,
   parameter int unsigned CNT_W     = 3,
   parameter int unsigned COST_W    = 10,
   parameter int unsigned FARE_BASE = DEF_FARE_BASE,
   parameter int unsigned FARE_STEP = DEF_FARE_STEP
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic              clear_i,
   input  logic [STN_W-1:0]  origin_i,
   input  logic [STN_W-1:0]  dest_i,
   input  logic [CNT_W-1:0]  count_i,
   output logic [COST_W-1:0] cost_next_o,
   output logic [COST_W-1:0] cost_o
);

   logic [31:0]       dist_w;
   logic [COST_W-1:0] cost_q;

   assign dist_w      = station_dist(32'(origin_i), 32'(dest_i));
   assign cost_next_o = COST_W'(32'(count_i) * (32'(FARE_BASE) + 32'(FARE_STEP) * dist_w));
   assign cost_o      = cost_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cost_q <= '0;
      end else if (clear_i) begin
         cost_q <= '0;
      end else if (load_i) begin
         cost_q <= cost_next_o;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ticket_vending_fsm.sv
`default_nettype none
// ticket_vending_fsm: request validation, fare, coin accumulation, issue/refund handshake.
// Define PAY_TIMEOUT_EN to abort payment after TIMEOUT_CYCLES cycles without a coin.
module ticket_vending_fsm
   import ticket_vending_pkg::*;
#(
   parameter int unsigned NUM_STATIONS   = DEF_NUM_STATIONS,
   parameter int unsigned MAX_TICKETS    = DEF_MAX_TICKETS,
   parameter int unsigned FARE_BASE      = DEF_FARE_BASE,
   parameter int unsigned FARE_STEP      = DEF_FARE_STEP,
   parameter int unsigned MONEY_W        = 6,
   parameter int unsigned COST_W         = 10,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   localparam int unsigned STN_W = $clog2(NUM_STATIONS + 1),
   localparam int unsigned CNT_W = $clog2(MAX_TICKETS + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sel_valid,
   input  logic [STN_W-1:0]   origin,
   input  logic [STN_W-1:0]   destination,
   input  logic [CNT_W-1:0]   ticket_count,
   input  logic               coin_valid,
   input  logic [MONEY_W-1:0] coin_value,
   input  logic               cancel,
   input  logic               dispense_ready,
   output logic [COST_W-1:0]  cost,
   output logic [COST_W-1:0]  paid,
   output logic [COST_W-1:0]  due,
   output logic [COST_W-1:0]  change,
   output logic               ticket_valid,
   output logic               refund_valid,
   output logic               sel_error,
   output logic [2:0]         state_o
);

   localparam logic [2:0] S_IDLE   = ST_IDLE;
   localparam logic [2:0] S_CALC   = ST_CALC;
   localparam logic [2:0] S_PAY    = ST_PAY;
   localparam logic [2:0] S_ISSUE  = ST_ISSUE;
   localparam logic [2:0] S_REFUND = ST_REFUND;

   localparam longint unsigned MAX_COST =
      longint'(MAX_TICKETS) * (longint'(FARE_BASE) + longint'(FARE_STEP) * (longint'(NUM_STATIONS) - 1));
   localparam logic [STN_W-1:0] MAX_STN = STN_W'(NUM_STATIONS);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TICKETS);

   if (MAX_COST >= (64'd1 << COST_W) || TIMEOUT_CYCLES == 0) begin : g_param_check
      $error("ticket_vending_fsm: worst-case cost does not fit COST_W or TIMEOUT_CYCLES is zero");
   end

   logic [2:0]         state_q, state_d;
   logic [STN_W-1:0]   origin_q, origin_d, dest_q, dest_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [COST_W-1:0]  paid_q, paid_d, due_q, due_d, change_q, change_d;
   logic               ticket_q, ticket_d, refund_q, refund_d, sel_err_q, sel_err_d;
   logic               cost_load, cost_clear, req_ok_w, abort_w, timeout_w;
   logic [COST_W-1:0]  cost_next_w, cost_w, coin_w, sum_w;
   logic [COST_W:0]    sum_ext_w;

   fare_calc #(
      .STN_W     (STN_W),
      .CNT_W     (CNT_W),
      .COST_W    (COST_W),
      .FARE_BASE (FARE_BASE),
      .FARE_STEP (FARE_STEP)
   ) u_fare_calc (
      .clk         (clk),
      .reset       (reset),
      .load_i      (cost_load),
      .clear_i     (cost_clear),
      .origin_i    (origin_q),
      .dest_i      (dest_q),
      .count_i     (count_q),
      .cost_next_o (cost_next_w),
      .cost_o      (cost_w)
   );

   assign req_ok_w = (origin != '0) && (origin <= MAX_STN) &&
                     (destination != '0) && (destination <= MAX_STN) &&
                     (origin != destination) &&
                     (ticket_count != '0) && (ticket_count <= MAX_CNT);

   // Paid total saturates instead of wrapping on a huge coin.
   assign coin_w    = coin_valid ? COST_W'(coin_value) : '0;
   assign sum_ext_w = {1'b0, paid_q} + {1'b0, coin_w};
   assign sum_w     = sum_ext_w[COST_W] ? '1 : sum_ext_w[COST_W-1:0];

`ifdef PAY_TIMEOUT_EN
   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMR_W-1:0] timer_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer_q <= '0;
      end else if (state_q != S_PAY || coin_valid) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_q + 1'b1;
      end
   end

   assign timeout_w = (state_q == S_PAY) && !coin_valid && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_w = 1'b0;
`endif

   assign abort_w = cancel || timeout_w;

   always_comb begin
      state_d    = state_q;
      origin_d   = origin_q;
      dest_d     = dest_q;
      count_d    = count_q;
      paid_d     = paid_q;
      due_d      = due_q;
      change_d   = change_q;
      ticket_d   = ticket_q;
      refund_d   = refund_q;
      sel_err_d  = 1'b0;
      cost_load  = 1'b0;
      cost_clear = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (sel_valid) begin
               if (req_ok_w) begin
                  origin_d = origin;
                  dest_d   = destination;
                  count_d  = ticket_count;
                  state_d  = S_CALC;
               end else begin
                  sel_err_d = 1'b1;
               end
            end
         end
         S_CALC: begin
            cost_load = 1'b1;
            paid_d    = '0;
            due_d     = cost_next_w;
            state_d   = S_PAY;
         end
         S_PAY: begin
            // Cancel wins over a completing coin; that coin is still refunded.
            if (abort_w) begin
               due_d = '0;
               if (sum_w == '0) begin
                  paid_d     = '0;
                  cost_clear = 1'b1;
                  state_d    = S_IDLE;
               end else begin
                  paid_d   = sum_w;
                  change_d = sum_w;
                  refund_d = 1'b1;
                  state_d  = S_REFUND;
               end
            end else if (coin_valid) begin
               paid_d = sum_w;
               if (sum_w >= cost_w) begin
                  change_d = sum_w - cost_w;
                  ticket_d = 1'b1;
                  due_d    = '0;
                  state_d  = S_ISSUE;
               end else begin
                  due_d = cost_w - sum_w;
               end
            end
         end
         S_ISSUE, S_REFUND: begin
            if (dispense_ready) begin
               cost_clear = 1'b1;
               paid_d     = '0;
               change_d   = '0;
               ticket_d   = 1'b0;
               refund_d   = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: begin
            cost_clear = 1'b1;
            paid_d     = '0;
            due_d      = '0;
            change_d   = '0;
            ticket_d   = 1'b0;
            refund_d   = 1'b0;
            state_d    = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         origin_q  <= '0;
         dest_q    <= '0;
         count_q   <= '0;
         paid_q    <= '0;
         due_q     <= '0;
         change_q  <= '0;
         ticket_q  <= 1'b0;
         refund_q  <= 1'b0;
         sel_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         origin_q  <= origin_d;
         dest_q    <= dest_d;
         count_q   <= count_d;
         paid_q    <= paid_d;
         due_q     <= due_d;
         change_q  <= change_d;
         ticket_q  <= ticket_d;
         refund_q  <= refund_d;
         sel_err_q <= sel_err_d;
      end
   end

   assign cost         = cost_w;
   assign paid         = paid_q;
   assign due          = due_q;
   assign change       = change_q;
   assign ticket_valid = ticket_q;
   assign refund_valid = refund_q;
   assign sel_error    = sel_err_q;
   assign state_o      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ticket_vending_fsm.sv
`default_nettype none
// tb_ticket_vending_fsm: directed scenarios plus random transactions checked against
// a transaction-level fare/payment model.
module tb_ticket_vending_fsm;

   localparam int TB_TIMEOUT = 1024;

   logic       clk = 1'b0;
   logic       reset;
   logic       sel_valid, coin_valid, cancel, dispense_ready;
   logic [3:0] origin, destination;
   logic [2:0] ticket_count;
   logic [5:0] coin_value;
   logic [9:0] cost, paid, due, change;
   logic       ticket_valid, refund_valid, sel_error;
   logic [2:0] state_o;

   int n_checks = 0;
   int n_errors = 0;
   int unsigned m_cost, m_paid;

   ticket_vending_fsm dut (
      .clk            (clk),
      .reset          (reset),
      .sel_valid      (sel_valid),
      .origin         (origin),
      .destination    (destination),
      .ticket_count   (ticket_count),
      .coin_valid     (coin_valid),
      .coin_value     (coin_value),
      .cancel         (cancel),
      .dispense_ready (dispense_ready),
      .cost           (cost),
      .paid           (paid),
      .due            (due),
      .change         (change),
      .ticket_valid   (ticket_valid),
      .refund_valid   (refund_valid),
      .sel_error      (sel_error),
      .state_o        (state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int unsigned fare(input int o, input int d, input int c);
      return c * (5 + 5 * ((o > d) ? (o - d) : (d - o)));
   endfunction

   function automatic bit req_valid(input int o, input int d, input int c);
      return (o >= 1) && (o <= 8) && (d >= 1) && (d <= 8) && (o != d) && (c >= 1) && (c <= 7);
   endfunction

   task automatic idle_outputs(input string tag);
      chk({tag, "_state"}, state_o, 0);
      chk({tag, "_cost"}, cost, 0);
      chk({tag, "_paid"}, paid, 0);
      chk({tag, "_due"}, due, 0);
      chk({tag, "_change"}, change, 0);
      chk({tag, "_tkt"}, ticket_valid, 0);
      chk({tag, "_ref"}, refund_valid, 0);
   endtask

   // Returns 1 when the request was accepted and PAY reached.
   task automatic request(input int o, input int d, input int c, output bit ok);
      sel_valid = 1'b1; origin = 4'(o); destination = 4'(d); ticket_count = 3'(c);
      step();
      sel_valid = 1'b0;
      ok = req_valid(o, d, c);
      if (!ok) begin
         chk("rej_err", sel_error, 1);
         chk("rej_state", state_o, 0);
         step();
         chk("rej_pulse", sel_error, 0);
         chk("rej_state2", state_o, 0);
      end else begin
         chk("acc_err", sel_error, 0);
         chk("calc_state", state_o, 1);
         step();
         m_cost = fare(o, d, c);
         m_paid = 0;
         chk("pay_state", state_o, 2);
         chk("pay_cost", cost, m_cost);
         chk("pay_paid0", paid, 0);
         chk("pay_due0", due, m_cost);
      end
   endtask

   // res: resulting state (0 idle, 2 pay, 3 issue, 4 refund); chg: expected change.
   task automatic coin(input bit cv, input int v, input bit can, output int res, output int unsigned chg);
      int unsigned sum;
      coin_valid = cv; coin_value = 6'(v); cancel = can;
      step();
      coin_valid = 1'b0; cancel = 1'b0;
      sum = m_paid + (cv ? v : 0);
      if (sum > 1023) sum = 1023;
      chg = 0;
      if (can && sum == 0) begin
         res = 0;
         idle_outputs("cancel0");
      end else if (can) begin
         res = 4; chg = sum;
         chk("ref_state", state_o, 4);
         chk("ref_valid", refund_valid, 1);
         chk("ref_tkt", ticket_valid, 0);
         chk("ref_change", change, chg);
         chk("ref_due", due, 0);
      end else if (sum >= m_cost) begin
         res = 3; chg = sum - m_cost;
         chk("iss_state", state_o, 3);
         chk("iss_valid", ticket_valid, 1);
         chk("iss_ref", refund_valid, 0);
         chk("iss_change", change, chg);
         chk("iss_due", due, 0);
      end else begin
         res = 2; m_paid = sum;
         chk("coin_state", state_o, 2);
         chk("coin_paid", paid, m_paid);
         chk("coin_due", due, m_cost - m_paid);
      end
   endtask

   // Holds off the dispenser for waitc cycles while toggling ignored inputs.
   task automatic dispense(input int waitc, input int kind, input int unsigned chg);
      for (int i = 0; i < waitc; i++) begin
         sel_valid = 1'($urandom_range(0, 1)); coin_valid = 1'($urandom_range(0, 1));
         cancel = 1'($urandom_range(0, 1)); coin_value = 6'($urandom_range(0, 63));
         origin = 4'd1; destination = 4'd2; ticket_count = 3'd1;
         step();
         chk("hold_state", state_o, kind);
         chk("hold_tkt", ticket_valid, (kind == 3) ? 1 : 0);
         chk("hold_ref", refund_valid, (kind == 4) ? 1 : 0);
         chk("hold_change", change, chg);
      end
      sel_valid = 1'b0; coin_valid = 1'b0; cancel = 1'b0;
      dispense_ready = 1'b1;
      step();
      dispense_ready = 1'b0;
      idle_outputs("done");
   endtask

   initial begin
      bit ok;
      int res;
      int unsigned chg;
      int o, d, c;

      reset = 1'b1; sel_valid = 0; coin_valid = 0; cancel = 0; dispense_ready = 0;
      origin = 0; destination = 0; ticket_count = 0; coin_value = 0;
      step(); step();
      idle_outputs("rst");
      chk("rst_selerr", sel_error, 0);
      reset = 1'b0;
      step();

      request(2, 5, 3, ok);
      coin(1'b1, 50, 1'b0, res, chg);
      coin(1'b1, 20, 1'b0, res, chg);
      chk("t1_change", chg, 10);
      dispense(3, res, chg);

      request(4, 1, 1, ok);
      chk("t2_cost", cost, 20);
      coin(1'b1, 20, 1'b0, res, chg);
      dispense(0, res, chg);

      request(3, 3, 2, ok);
      request(3, 0, 2, ok);
      request(2, 5, 0, ok);

      request(1, 8, 7, ok);
      coin(1'b1, 10, 1'b0, res, chg);
      coin(1'b1, 20, 1'b0, res, chg);
      coin(1'b1, 5, 1'b1, res, chg);
      chk("t4_refund", chg, 35);
      dispense(2, res, chg);

      request(1, 2, 1, ok);
      coin(1'b0, 0, 1'b1, res, chg);
      chk("t5_direct_idle", res, 0);

      request(2, 5, 3, ok);
      coin(1'b1, 10, 1'b0, res, chg);
`ifdef PAY_TIMEOUT_EN
      for (int i = 0; i < TB_TIMEOUT + 4 && !refund_valid; i++) step();
      chk("to_refund", refund_valid, 1);
      chk("to_change", change, 10);
      dispense(0, 4, 10);
`else
      for (int i = 0; i < 40; i++) step();
      chk("noto_state", state_o, 2);
      chk("noto_paid", paid, 10);
      coin(1'b0, 0, 1'b1, res, chg);
      dispense(1, res, chg);
`endif

      request(2, 5, 3, ok);
      coin(1'b1, 30, 1'b0, res, chg);
      #2 reset = 1'b1;
      #1;
      idle_outputs("async_rst");
      step();
      reset = 1'b0;
      step();
      idle_outputs("post_rst");

      for (int t = 0; t < 60; t++) begin
         o = $urandom_range(0, 9); d = $urandom_range(0, 9); c = $urandom_range(0, 7);
         request(o, d, c, ok);
         if (ok) begin
            res = 2;
            for (int k = 0; k < 40 && res == 2; k++)
               coin(1'($urandom_range(0, 3) != 0), $urandom_range(0, 63),
                    1'($urandom_range(0, 9) == 0), res, chg);
            if (res == 2) coin(1'b0, 0, 1'b1, res, chg);
            if (res == 3 || res == 4) dispense($urandom_range(0, 3), res, chg);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ticket_vending_fsm.md
# ticket_vending_fsm

Parametrised multi-station ticket vending controller, successor to the fixed four-state vending machine. Accepts a validated origin/destination/quantity request, computes a distance-based fare, accumulates coins, then issues tickets with change or refunds on cancel. Sits between the front-panel input decoder and the ticket/coin dispenser, and handshakes with the dispenser for every issue or refund.

## Interface
- NUM_STATIONS, 8: stations numbered 1..NUM_STATIONS; 0 means none.
- MAX_TICKETS, 7: maximum tickets per transaction.
- FARE_BASE, 5: fare component per ticket, independent of distance.
- FARE_STEP, 5: fare added per station of distance.
- MONEY_W, 6: coin value width.
- COST_W, 10: width of cost, paid, due and change.
- TIMEOUT_CYCLES, 1024: payment idle timeout; used only with the macro.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- sel_valid  in  1  one-cycle request strobe, sampled only in IDLE.
- origin, destination  in  STN_W = $clog2(NUM_STATIONS+1)  station numbers.
- ticket_count  in  CNT_W = $clog2(MAX_TICKETS+1)  requested quantity.
- coin_valid  in  1  coin strobe, sampled only in PAY.
- coin_value  in  MONEY_W  value of the inserted coin.
- cancel  in  1  abort request, honoured only in PAY.
- dispense_ready  in  1  dispenser has taken ticket or refund.
- cost  out  COST_W  latched total price.
- paid  out  COST_W  money accumulated so far.
- due  out  COST_W  cost − paid in PAY; otherwise 0.
- change  out  COST_W  money to return, valid with ticket_valid or refund_valid.
- ticket_valid  out  1  issue tickets; held until dispense_ready.
- refund_valid  out  1  refund change; held until dispense_ready.
- sel_error  out  1  one-cycle pulse on rejected request.
- state_o  out  3  current state encoding.

## Operation
- States: IDLE=0, CALC=1, PAY=2, ISSUE=3, REFUND=4. Unused encodings go to IDLE.
- IDLE: on sel_valid, the request is valid when:
  - origin and destination are each in 1..NUM_STATIONS;
  - origin ≠ destination;
  - ticket_count is in 1..MAX_TICKETS.
- IDLE, valid request: latch the inputs and go to CALC. Invalid request: pulse sel_error and stay in IDLE.
- CALC: cost = ticket_count × (FARE_BASE + FARE_STEP × |destination − origin|), computed unsigned; next state is PAY.
- PAY, coin_valid: sum = paid + coin_value, saturating at 2^COST_W − 1.
  - sum ≥ cost: go to ISSUE with change = sum − cost.
  - Otherwise: paid ← sum.
- PAY, cancel (including cancel with coin_valid in the same cycle): the coin is counted. Go to REFUND with change = paid + coin.
- PAY, cancel with zero total: go directly to IDLE. No refund is raised.
- ISSUE/REFUND: hold the matching valid and change until dispense_ready. Then clear cost, paid, change and go to IDLE.
- sel_valid, coin_valid and cancel are ignored outside their sampling states.
- Elaboration check: MAX_TICKETS × (FARE_BASE + FARE_STEP × (NUM_STATIONS − 1)) < 2^COST_W. Fail with $error otherwise.

## Timing
- All outputs are registered. Reset values: every output is 0 and state_o = IDLE.
- Reset asserted mid-transaction discards the money without a refund. The panel logs this event separately.
- Latency, IDLE→PAY: sel_valid at edge N gives CALC after edge N and PAY after edge N+1; cost is valid in PAY.
- Latency, final coin: the coin at edge M gives ticket_valid high after edge M.
- ticket_valid and refund_valid are never high together.
- When dispense_ready is sampled high at edge K, the valid drops after edge K and state is IDLE. dispense_ready may already be high on entry, giving a one-cycle ISSUE.
- due updates in the same cycle as paid.

## Configuration
- PAY_TIMEOUT_EN defined:
  - A counter runs in PAY and is cleared on entry and on every coin.
  - On reaching TIMEOUT_CYCLES it acts exactly like cancel: REFUND if paid > 0, else IDLE.
- PAY_TIMEOUT_EN undefined: no counter, and PAY waits indefinitely.

## Structure
- Package ticket_vending_pkg holds:
  - the state enum;
  - default fare constants;
  - a function for the |d − o| distance.
- Sub-module fare_calc computes the cost, combinational with a registered output in CALC.
- The FSM, accumulator and timeout counter stay in the top module.

## Test plan
- Reset asserted in PAY with paid=30 → all outputs 0, state_o=0 immediately, no refund_valid.
- Request origin=2, dest=5, count=3; coins 50, 20 → cost=60; due=10 after the first coin; ticket_valid with change=10 until dispense_ready.
- Request origin=4, dest=1, count=1 → cost=20 (reverse direction); a single coin 20 → ticket_valid with change=0.
- Invalid requests, each → one sel_error pulse and state stays IDLE:
  - origin=dest=3;
  - dest=0;
  - count=0.
- Pay 10 then 20, then cancel together with a coin of 5 → refund_valid with change=35; cancel with paid=0 → IDLE directly.
- With PAY_TIMEOUT_EN and TIMEOUT_CYCLES=16: pay 10, then idle for 16 cycles → refund_valid with change=10. Coins every 10 cycles → no timeout.
